// File: rtl/crc_pkg.sv
// Shared CRC-24 definitions: polynomials, attach FSM states and the
// bit-serial byte step (MSB first, no reflection, no final XOR).
package crc_pkg;

  localparam logic [23:0] CRC24A_POLY = 24'h864CFB;
  localparam logic [23:0] CRC24B_POLY = 24'h800063;

  typedef enum logic [1:0] {
    DATA,
    CRC_H,
    CRC_M,
    CRC_L
  } state_t;

  function automatic logic [23:0] crc24_step(
    input logic [23:0] crc,
    input logic [7:0]  d,
    input logic [23:0] poly
  );
    logic [23:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[23] ^ d[i];
      c  = {c[22:0], 1'b0} ^ (fb ? poly : 24'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc24_byte_step.sv
// Combinational CRC-24 update by one byte.
// Ports: crc_in (current CRC), d_in (byte), crc_out (updated CRC).
module crc24_byte_step
  import crc_pkg::*;
#(
  parameter logic [23:0] POLY = CRC24A_POLY
) (
  input  logic [23:0] crc_in,
  input  logic [7:0]  d_in,
  output logic [23:0] crc_out
);

  assign crc_out = crc24_step(crc_in, d_in, POLY);

endmodule

// File: rtl/crc_attach.sv
// Streams payload bytes through one output register and appends the
// 24-bit CRC (high, mid, low byte) after the byte flagged in_last.
// Ports: clk, reset (sync, active low), in_* byte stream with ready,
// out_* byte stream with ready, frame_len (payload count, saturating).
module crc_attach
  import crc_pkg::*;
#(
  parameter logic [23:0] POLY = CRC24A_POLY,
  parameter logic [23:0] INIT = 24'h000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frame_len
);

  state_t      state, state_n;
  logic [23:0] crc, crc_n, crc_step;
  logic [15:0] len_n;
  logic        restart, restart_n;
  logic [7:0]  od_n;
  logic        ov_n, ol_n;
  logic        slot_free;
  logic        take;

  crc24_byte_step #(
    .POLY(POLY)
  ) u_step (
    .crc_in (crc),
    .d_in   (in_data),
    .crc_out(crc_step)
  );

  assign slot_free = !out_valid || out_ready;
  // Gated by reset so the source sees no acceptance while held in reset.
  assign in_ready  = reset && (state == DATA) && slot_free;
  assign take      = in_valid && in_ready;

  always_comb begin
    state_n   = state;
    crc_n     = crc;
    len_n     = frame_len;
    restart_n = restart;
    od_n      = out_data;
    ov_n      = out_valid;
    ol_n      = out_last;
    if (slot_free) begin
      ov_n = 1'b0;
      ol_n = 1'b0;
    end
    unique case (state)
      DATA: begin
        if (take) begin
          od_n      = in_data;
          ov_n      = 1'b1;
          ol_n      = 1'b0;
          crc_n     = crc_step;
          restart_n = 1'b0;
          // Count restarts on the first byte of the next frame so the
          // previous frame's length stays visible until then.
          if (restart)
            len_n = 16'd1;
          else if (frame_len != 16'hFFFF)
            len_n = frame_len + 16'd1;
          if (in_last)
            state_n = CRC_H;
        end
      end
      CRC_H: begin
        if (slot_free) begin
          od_n    = crc[23:16];
          ov_n    = 1'b1;
          state_n = CRC_M;
        end
      end
      CRC_M: begin
        if (slot_free) begin
          od_n    = crc[15:8];
          ov_n    = 1'b1;
          state_n = CRC_L;
        end
      end
      CRC_L: begin
        if (slot_free) begin
          od_n      = crc[7:0];
          ov_n      = 1'b1;
          ol_n      = 1'b1;
          crc_n     = INIT;
          restart_n = 1'b1;
          state_n   = DATA;
        end
      end
      default: state_n = DATA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= DATA;
      crc       <= INIT;
      frame_len <= 16'd0;
      restart   <= 1'b0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      crc       <= crc_n;
      frame_len <= len_n;
      restart   <= restart_n;
      out_data  <= od_n;
      out_valid <= ov_n;
      out_last  <= ol_n;
    end
  end

endmodule

// File: tb/tb_crc_attach.sv
// Self-checking bench for crc_attach: table of one-byte frames plus
// sequences for back-to-back, stall, reset and long-frame cases.
module tb_crc_attach;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [15:0] frame_len;

  crc_attach dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .out_ready(out_ready),
    .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;
  typedef struct {
    logic [7:0]  d;
    logic [23:0] crc;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   npop = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   stall_mode = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_d;
  logic       prev_l;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_crc(input bq_t q);
    logic [23:0] c = 24'h0;
    logic        fb;
    foreach (q[k])
      for (int i = 7; i >= 0; i--) begin
        fb = c[23] ^ q[k][i];
        c  = {c[22:0], 1'b0};
        if (fb) c = c ^ 24'h864CFB;
      end
    return c;
  endfunction

  always @(posedge clk) cyc++;

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && reset) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", {24'd0, out_data}, {24'd0, prev_d});
      check("stall_last", {31'd0, out_last}, {31'd0, prev_l});
    end
    prev_stall = reset && out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h want none", out_data);
      end else begin
        e = sb.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.d});
        check("out_last", {31'd0, out_last}, {31'd0, e.l});
      end
      npop++;
      if (npop == 1) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  // Backpressure pattern 1,0,0,1 when enabled.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) begin
        out_ready = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l,
                           output int waits);
    bit done = 0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: d, l: 1'b0});
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        waits++;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_timeout: got 0 want 1");
    end
  endtask

  task automatic send_frame(input bq_t q, input logic [23:0] c,
                            output int w0);
    int w;
    w0 = 0;
    foreach (q[k]) begin
      send_byte(q[k], k == q.size() - 1, w);
      if (k == 0) w0 = w;
      if (k == q.size() - 1) begin
        sb.push_back('{d: c[23:16], l: 1'b0});
        sb.push_back('{d: c[15:8], l: 1'b0});
        sb.push_back('{d: c[7:0], l: 1'b1});
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d left want 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[5];
    bq_t  q;
    int   w;

    tbl[0] = '{d: 8'h01, crc: 24'h864CFB};
    tbl[1] = '{d: 8'h02, crc: 24'h8AD50D};
    tbl[2] = '{d: 8'h00, crc: 24'h000000};
    q = '{8'hFF};
    tbl[3] = '{d: 8'hFF, crc: ref_crc(q)};
    q = '{8'hA5};
    tbl[4] = '{d: 8'hA5, crc: ref_crc(q)};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_frame_len", {16'd0, frame_len}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // One-byte frames from the table.
    foreach (tbl[i]) begin
      q = '{tbl[i].d};
      send_frame(q, tbl[i].crc, w);
      check("latency_valid", {31'd0, out_valid}, 32'd1);
      check("latency_data", {24'd0, out_data}, {24'd0, tbl[i].d});
      idle();
      drain();
      check("len_1byte", {16'd0, frame_len}, 32'd1);
    end
    check("idle_valid", {31'd0, out_valid}, 32'd0);

    // Back-to-back frames {00,01} then {02}.
    npop = 0;
    q = '{8'h00, 8'h01};
    send_frame(q, 24'h864CFB, w);
    q = '{8'h02};
    send_frame(q, 24'h8AD50D, w);
    check("b2b_gap", w, 32'd3);
    idle();
    drain();
    check("b2b_count", npop, 32'd9);
    check("b2b_span", last_cyc - first_cyc, 32'd8);
    check("b2b_len", {16'd0, frame_len}, 32'd1);

    // Stalled output.
    stall_mode = 1;
    q = '{8'h01};
    send_frame(q, 24'h864CFB, w);
    idle();
    drain();
    repeat (4) @(posedge clk);
    stall_mode = 0;
    #1;
    out_ready = 1'b1;
    drain();

    // Reset after two bytes of a frame.
    send_byte(8'h11, 1'b0, w);
    send_byte(8'h22, 1'b0, w);
    reset = 1'b0;
    idle();
    #1;
    check("inrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("postrst_valid", {31'd0, out_valid}, 32'd0);
    check("postrst_len", {16'd0, frame_len}, 32'd0);
    check("postrst_ready", {31'd0, in_ready}, 32'd1);
    drain();
    q = '{8'h01};
    send_frame(q, 24'h864CFB, w);
    idle();
    drain();
    check("postrst_len1", {16'd0, frame_len}, 32'd1);

    // Long random frame.
    q = {};
    for (int i = 0; i < 129; i++)
      q.push_back(8'($urandom_range(0, 255)));
    npop = 0;
    send_frame(q, ref_crc(q), w);
    idle();
    drain();
    check("long_count", npop, 32'd132);
    check("long_span", last_cyc - first_cyc, 32'd131);
    check("long_len", {16'd0, frame_len}, 32'd129);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_attach.md
CRC_ATTACH -- requirements
Module: crc_attach

Interface
REQ-001 Parameter POLY, default 24'h864CFB, CRC-24A generator polynomial with implicit x^24 term.
REQ-002 Parameter INIT, default 24'h000000, CRC register start value for each frame.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (asserted when 0).
REQ-005 in_valid  in  1  upstream byte valid.
REQ-006 in_data  in  8  upstream payload byte.
REQ-007 in_last  in  1  marks final payload byte of a transport block.
REQ-008 in_ready  out  1  block accepts a byte this cycle.
REQ-009 out_valid  out  1  output byte valid.
REQ-010 out_data  out  8  payload byte or CRC byte.
REQ-011 out_last  out  1  marks final output byte (CRC low byte).
REQ-012 out_ready  in  1  downstream accepts output byte.
REQ-013 frame_len  out  16  payload bytes accepted in the current/last frame, excluding CRC.

Function
REQ-014 Input transfer shall occur when in_valid && in_ready; output transfer shall occur when out_valid && out_ready.
REQ-015 The output shall be a single register stage: "slot free" = !out_valid || out_ready.
REQ-016 States: DATA, CRC_H, CRC_M, CRC_L; reset state DATA.
REQ-017 in_ready shall equal (state==DATA) && slot free; it shall be 0 in all CRC states.
REQ-018 DATA: on input transfer, load out_data=in_data, out_valid=1, out_last=0, crc=step(crc,in_data), frame_len+1.
REQ-019 DATA: on input transfer with in_last=1, go to CRC_H.
REQ-020 CRC_H/CRC_M/CRC_L: when slot free, load out_data=crc[23:16] / crc[15:8] / crc[7:0], out_valid=1, and advance CRC_H->CRC_M->CRC_L->DATA.
REQ-021 The CRC_L load shall set out_last=1, reset crc to INIT, and reset frame_len to 0 on the next frame's first accepted byte (frame_len holds the final count until then).
REQ-022 When the slot is free and no new byte is loaded, out_valid shall drop to 0.
REQ-023 Byte latency shall be exactly 1 cycle from input transfer to out_valid with no backpressure; with continuous valid/ready, a frame of N bytes shall produce N+3 output bytes in N+3 consecutive cycles.
REQ-024 step() shall process 8 bits MSB first: fb=crc[23]^bit; crc=(crc<<1)[23:0] ^ (fb ? POLY : 0); no final XOR, no reflection.
REQ-025 Output registers (out_data, out_valid, out_last) shall hold while out_valid && !out_ready.
REQ-026 in_valid, in_data and in_last shall be ignored outside DATA.
REQ-027 A one-byte frame (in_last on first byte) shall be legal; a zero-length frame is not representable.
REQ-028 frame_len shall saturate at 16'hFFFF without wrapping.

Reset
REQ-029 When reset==0 at a clock edge, the block shall set state=DATA, crc=INIT, frame_len=0, out_valid=0, out_last=0, out_data=8'h00.
REQ-030 Reset mid-frame or mid-CRC shall discard the partial frame; no CRC bytes shall be emitted for it.
REQ-031 in_ready shall be 0 during reset and the first cycle after release it shall be 1.

Structure
REQ-032 Package crc_pkg shall hold CRC24A_POLY, CRC24B_POLY (24'h800063), the state enum, and the byte-step function.
REQ-033 The combinational sub-module crc24_byte_step (crc_in[23:0], d_in[7:0], crc_out[23:0]) shall implement step().
REQ-034 The implementation shall instantiate exactly one crc24_byte_step and shall not use a clock or reset inside it.

Verification
REQ-035 Frame {0x01}, out_ready=1 -> out 01,86,4C,FB; out_last on FB; frame_len=1.
REQ-036 Frame {0x02} -> out 02,8A,D5,0D; Frame {0x00} -> out 00,00,00,00.
REQ-037 Frame {0x00,0x01} back-to-back with frame {0x02} -> out 00,01,86,4C,FB,02,8A,D5,0D; CRC restarts at 0; in_ready is low for 3 cycles between frames.
REQ-038 Frame {0x01} with out_ready toggling 1,0,0,1,... -> same byte sequence; out_data stable while stalled; no byte lost or duplicated.
REQ-039 reset=0 for 1 cycle after 2 bytes of a frame -> out_valid=0 next cycle; the following frame {0x01} yields 01,86,4C,FB.
REQ-040 129-byte random frame vs reference model (POLY, MSB first) -> 132 output bytes, CRC matches, frame_len=129.
